mul_share_ctrl: RTL and testbench
=================================

Name: mul_share_ctrl

Overview:
Scheduler that shares one combinational 64x64 Wallace multiplier between two requesters.
- Round-robin arbitration between the two requesters.
- Registers the granted operands onto the multiplier inputs and waits a fixed settle time through the deep adder tree.
- Captures the 128-bit product and carry, then returns them with the requester id over a valid/ready response channel.
- Sits between the core's issue logic and the multiplier datapath; one operation is outstanding at a time.

Parameters:
- DATA_W, 64, operand width; product width is 2*DATA_W.
- SETTLE_CYCLES, 4, cycles the registered operands are held before the product is sampled; legal range 1..15.
- COUNT_W, 8, width of the wrapping completed-operation counter.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit i is requester i
- req_ready  out  2  per-requester accept; at most one bit high
- req_a0, req_b0  in  DATA_W  operands of requester 0
- req_a1, req_b1  in  DATA_W  operands of requester 1
- mul_a, mul_b  out  DATA_W  registered operands to the multiplier
- mul_pro  in  2*DATA_W  multiplier product
- mul_carry  in  1  multiplier final carry
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_pro  out  2*DATA_W  captured product
- resp_carry  out  1  captured carry
- resp_id  out  1  requester that owns the response
- busy  out  1  high whenever state != IDLE
- op_count  out  COUNT_W  completed responses, wraps modulo 2^COUNT_W

Behaviour:
- Reset: synchronous, one clock, active-high; rst dominates all other inputs.
  - State = IDLE.
  - req_ready = 0; resp_valid = 0; resp_pro = 0; resp_carry = 0; resp_id = 0.
  - mul_a = mul_b = 0; busy = 0; op_count = 0.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
- IDLE:
  - grant = the requester with req_valid high.
  - If both are valid, grant = ~last.
  - req_ready[grant] = 1, combinationally from req_valid and state == IDLE; otherwise req_ready = 0.
- Transfer: occurs when req_valid[i] & req_ready[i]. On that edge:
  - mul_a/mul_b <= the granted operands; resp_id <= i; last <= i.
  - cnt <= SETTLE_CYCLES-1; state <= WAIT.
- WAIT:
  - mul_a/mul_b are held stable; cnt decrements each cycle.
  - At cnt == 0: resp_pro <= mul_pro; resp_carry <= mul_carry; resp_valid <= 1; state <= RESP.
- RESP:
  - resp_* is held stable while resp_ready = 0.
  - On resp_valid & resp_ready: resp_valid <= 0; op_count <= op_count+1 (wrapping); state <= IDLE.
- Latency: accept in cycle T gives resp_valid first high in cycle T+SETTLE_CYCLES+1. With the default, accept at cycle 0 gives the response at cycle 5.
- Throughput: best case one operation per SETTLE_CYCLES+2 cycles. No request is accepted in WAIT or RESP.
- mul_a/mul_b keep their last value in IDLE; they are not cleared after a response.
- req_valid dropping before the grant has no effect. Requesters hold operands stable while valid is high.
- resp_ready high outside RESP is ignored.
- Reset mid-operation (WAIT or RESP) discards the operation: no response, op_count unchanged.
- busy is registered-state decoded; it is 0 only in IDLE.

Decomposition:
- Shared package: state encoding constants IDLE=2'd0, WAIT=2'd1, RESP=2'd2, and the counter width for cnt (4 bits).
- One natural sub-module: mul_rr_pick, a combinational 2-way round-robin picker.
  - Inputs: req_valid[1:0], last.
  - Outputs: grant_valid, grant_id.
- The FSM, operand registers, settle counter and response registers live in mul_share_ctrl.
- The multiplier is instantiated by the parent and connected via mul_a/mul_b/mul_pro/mul_carry.

Test Plan:
- Single request: req_valid=2'b01, a0=3, b0=5 at cycle 0 -> req_ready=2'b01 in cycle 0; resp_valid in cycle 5 with resp_pro=15, resp_carry=0, resp_id=0; op_count=1 after resp_ready.
- Max operands: a1=b1=0xFFFFFFFFFFFFFFFF -> resp_pro=0xFFFFFFFFFFFFFFFE_0000000000000001, resp_carry=0, resp_id=1.
- Tie after reset: both valid (a0=2,b0=7; a1=4,b1=9) held -> requester 0 served first (14), then requester 1 (36); a third tie grants requester 0 again.
- Backpressure: resp_ready low for 3 cycles in RESP -> resp_pro/resp_id stable, busy=1, req_ready=0 despite req_valid=2'b11; completes on the first resp_ready high.
- Reset mid-WAIT: rst at cycle 2 after accept -> next cycle state IDLE, resp_valid never asserts, op_count=0, mul_a=mul_b=0.
- Counter wrap: 256 back-to-back operations with COUNT_W=8 -> op_count returns to 0; throughput 6 cycles/op with resp_ready tied high.

Source files
------------

// File: rtl/mul_share_ctrl_pkg.sv
// Shared types and constants for the multiplier-sharing scheduler.
// Holds the FSM state encoding and the settle-counter width.
package mul_share_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    // One-hot accept vector for a 2-way grant id.
    function automatic logic [1:0] grant_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mul_rr_pick.sv
// Combinational 2-way round-robin picker: a lone requester always wins,
// and on a tie the requester that was not served last wins.
module mul_rr_pick (
    input  logic [1:0] req_valid,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req_valid;
        grant_id    = 1'b0;
        if (req_valid == 2'b11) begin
            grant_id = ~last;
        end else if (req_valid[1]) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Schedules two requesters onto one shared combinational multiplier:
// registers the granted operands, waits out the settle time, then returns the product.
module mul_share_ctrl
    import mul_share_ctrl_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter int SETTLE_CYCLES = 4,
    parameter int COUNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [DATA_W-1:0]     req_a0,
    input  logic [DATA_W-1:0]     req_b0,
    input  logic [DATA_W-1:0]     req_a1,
    input  logic [DATA_W-1:0]     req_b1,
    output logic [DATA_W-1:0]     mul_a,
    output logic [DATA_W-1:0]     mul_b,
    input  logic [2*DATA_W-1:0]   mul_pro,
    input  logic                  mul_carry,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [2*DATA_W-1:0]   resp_pro,
    output logic                  resp_carry,
    output logic                  resp_id,
    output logic                  busy,
    output logic [COUNT_W-1:0]    op_count
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   last_reg;
    logic [DATA_W-1:0]      mul_a_reg;
    logic [DATA_W-1:0]      mul_b_reg;
    logic                   resp_valid_reg;
    logic [2*DATA_W-1:0]    resp_pro_reg;
    logic                   resp_carry_reg;
    logic                   resp_id_reg;
    logic [COUNT_W-1:0]     op_count_reg;

    logic                   grant_valid;
    logic                   grant_id;
    logic                   accept_en;
    logic [1:0]             grant_vec;
    logic [DATA_W-1:0]      sel_a [2];
    logic [DATA_W-1:0]      sel_b [2];

    mul_rr_pick u_pick (
        .req_valid   (req_valid),
        .last        (last_reg),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Reset gates the accept so no requester sees ready during rst.
    assign accept_en = (state_reg == IDLE) && grant_valid && !rst;
    assign grant_vec = grant_onehot(grant_id);

    assign sel_a[0] = req_a0;
    assign sel_b[0] = req_b0;
    assign sel_a[1] = req_a1;
    assign sel_b[1] = req_b1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = accept_en & grant_vec[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            last_reg       <= 1'b1;
            mul_a_reg      <= '0;
            mul_b_reg      <= '0;
            resp_valid_reg <= 1'b0;
            resp_pro_reg   <= '0;
            resp_carry_reg <= 1'b0;
            resp_id_reg    <= 1'b0;
            op_count_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept_en) begin
                        mul_a_reg   <= sel_a[grant_id];
                        mul_b_reg   <= sel_b[grant_id];
                        resp_id_reg <= grant_id;
                        last_reg    <= grant_id;
                        cnt_reg     <= CNT_LOAD;
                        state_reg   <= WAIT;
                    end
                end
                WAIT: begin
                    // Operands stay on the multiplier until the adder tree has settled.
                    if (cnt_reg == '0) begin
                        resp_pro_reg   <= mul_pro;
                        resp_carry_reg <= mul_carry;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_valid_reg && resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        op_count_reg   <= op_count_reg + COUNT_W'(1);
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign mul_a      = mul_a_reg;
    assign mul_b      = mul_b_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_pro   = resp_pro_reg;
    assign resp_carry = resp_carry_reg;
    assign resp_id    = resp_id_reg;
    assign op_count   = op_count_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl: table of single operations plus
// sequences for backpressure, reset mid-operation and counter wrap.
module tb_mul_share_ctrl;

    localparam int DW = 64;
    localparam int SETTLE = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [DW-1:0]   req_a0, req_b0, req_a1, req_b1;
    logic [DW-1:0]   mul_a, mul_b;
    logic [2*DW-1:0] mul_pro;
    logic            mul_carry;
    logic            resp_valid;
    logic            resp_ready;
    logic [2*DW-1:0] resp_pro;
    logic            resp_carry;
    logic            resp_id;
    logic            busy;
    logic [7:0]      op_count;
    logic            carry_in;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared multiplier.
    assign mul_pro   = {{DW{1'b0}}, mul_a} * {{DW{1'b0}}, mul_b};
    assign mul_carry = carry_in;

    mul_share_ctrl #(.DATA_W(DW), .SETTLE_CYCLES(SETTLE), .COUNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_pro    (mul_pro),
        .mul_carry  (mul_carry),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_pro   (resp_pro),
        .resp_carry (resp_carry),
        .resp_id    (resp_id),
        .busy       (busy),
        .op_count   (op_count)
    );

    typedef struct {
        logic [1:0]      valid;
        logic [DW-1:0]   a0, b0, a1, b1;
        logic            carry;
        logic            id;
        logic [2*DW-1:0] pro;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic set_ops(input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                           input logic [DW-1:0] a1, input logic [DW-1:0] b1);
        req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
    endtask

    // Waits for resp_valid; returns cycles elapsed (capped at the bound).
    task automatic wait_resp(input int start, output int lat);
        lat = start;
        while (!resp_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int exp_count;
        int n_resp, n_id0, resp_cycle, cyc, quiet_hits;
        logic [2*DW-1:0] exp_a, exp_b;

        // a0, b0, a1, b1 ; expected id follows the round-robin pointer from reset (last=1)
        vecs[0] = '{2'b01, 64'd3, 64'd5, 64'd0, 64'd0, 1'b0, 1'b0, 128'd15};
        vecs[1] = '{2'b10, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    1'b0, 1'b1, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vecs[2] = '{2'b11, 64'd2, 64'd7, 64'd4, 64'd9, 1'b0, 1'b0, 128'd14};
        vecs[3] = '{2'b11, 64'd2, 64'd7, 64'd4, 64'd9, 1'b0, 1'b1, 128'd36};
        vecs[4] = '{2'b11, 64'd2, 64'd7, 64'd4, 64'd9, 1'b0, 1'b0, 128'd14};
        vecs[5] = '{2'b01, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 64'd0,
                    1'b1, 1'b0, 128'h1_0000_0000_0000_0000};
        vecs[6] = '{2'b11, 64'd11, 64'd13, 64'd100, 64'd1000, 1'b0, 1'b1, 128'd100000};
        vecs[7] = '{2'b10, 64'd5, 64'd5, 64'd0, 64'hDEAD, 1'b0, 1'b1, 128'd0};

        rst = 1'b1; req_valid = 2'b11; resp_ready = 1'b0; carry_in = 1'b0;
        set_ops(64'd1, 64'd2, 64'd3, 64'd4);
        step(); step();
        chk("reset_req_ready", 128'(req_ready), 128'd0);
        chk("reset_resp_valid", 128'(resp_valid), 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_op_count", 128'(op_count), 128'd0);
        chk("reset_mul_a", 128'(mul_a), 128'd0);
        chk("reset_resp_pro", resp_pro, 128'd0);
        rst = 1'b0; req_valid = 2'b00;
        step();
        exp_count = 0;

        for (int i = 0; i < 8; i++) begin
            req_valid = vecs[i].valid;
            set_ops(vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1);
            carry_in = vecs[i].carry;
            #1;
            chk($sformatf("v%0d_req_ready", i), 128'(req_ready), vecs[i].id ? 128'd2 : 128'd1);
            step();
            req_valid = 2'b00;
            chk($sformatf("v%0d_busy_wait", i), 128'(busy), 128'd1);
            wait_resp(1, lat);
            chk($sformatf("v%0d_latency", i), 128'(lat), 128'(SETTLE + 1));
            chk($sformatf("v%0d_pro", i), resp_pro, vecs[i].pro);
            chk($sformatf("v%0d_carry", i), 128'(resp_carry), 128'(vecs[i].carry));
            chk($sformatf("v%0d_id", i), 128'(resp_id), 128'(vecs[i].id));
            exp_a = vecs[i].id ? 128'(vecs[i].a1) : 128'(vecs[i].a0);
            exp_b = vecs[i].id ? 128'(vecs[i].b1) : 128'(vecs[i].b0);
            chk($sformatf("v%0d_mul_a", i), 128'(mul_a), exp_a);
            chk($sformatf("v%0d_mul_b", i), 128'(mul_b), exp_b);
            resp_ready = 1'b1;
            step();
            resp_ready = 1'b0;
            exp_count++;
            chk($sformatf("v%0d_op_count", i), 128'(op_count), 128'(exp_count));
            chk($sformatf("v%0d_idle", i), 128'({busy, resp_valid}), 128'd0);
            chk($sformatf("v%0d_mul_a_kept", i), 128'(mul_a), exp_a);
        end

        // Backpressure with both requesters held valid; last=1 so requester 0 goes first.
        req_valid = 2'b11;
        set_ops(64'd2, 64'd7, 64'd4, 64'd9);
        carry_in = 1'b0;
        step();
        wait_resp(1, lat);
        chk("bp_latency", 128'(lat), 128'(SETTLE + 1));
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp%0d_pro", k), resp_pro, 128'd14);
            chk($sformatf("bp%0d_id", k), 128'(resp_id), 128'd0);
            chk($sformatf("bp%0d_busy_ready", k), 128'({busy, resp_valid, req_ready}), 128'b1100);
            step();
        end
        chk("bp_still_valid", 128'(resp_valid), 128'd1);
        resp_ready = 1'b1;
        step();
        exp_count++;
        chk("bp_op_count", 128'(op_count), 128'(exp_count));
        chk("bp_next_grant", 128'(req_ready), 128'd2);
        step();
        req_valid = 2'b00;
        wait_resp(1, lat);
        chk("bp_second_pro", resp_pro, 128'd36);
        chk("bp_second_id", 128'(resp_id), 128'd1);
        step();
        resp_ready = 1'b0;
        exp_count++;
        chk("bp_second_count", 128'(op_count), 128'(exp_count));

        // Reset two cycles into WAIT discards the operation.
        req_valid = 2'b01;
        set_ops(64'd5, 64'd6, 64'd0, 64'd0);
        step();
        req_valid = 2'b00;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_wait_busy", 128'(busy), 128'd0);
        chk("rst_wait_op_count", 128'(op_count), 128'd0);
        chk("rst_wait_mul", 128'({mul_a, mul_b}), 128'd0);
        quiet_hits = 0;
        for (int k = 0; k < 10; k++) begin
            if (resp_valid) quiet_hits++;
            step();
        end
        chk("rst_wait_no_resp", 128'(quiet_hits), 128'd0);

        // 256 back-to-back ties with resp_ready tied high; first grant goes to requester 0.
        req_valid = 2'b11;
        resp_ready = 1'b1;
        set_ops(64'd2, 64'd7, 64'd4, 64'd9);
        n_resp = 0; n_id0 = 0; resp_cycle = 0; cyc = 0;
        while (n_resp < 256 && cyc < 2000) begin
            if (resp_valid) begin
                if (n_resp == 0) chk("wrap_first_id", 128'(resp_id), 128'd0);
                if (resp_pro !== (resp_id ? 128'd36 : 128'd14))
                    chk("wrap_pro", resp_pro, resp_id ? 128'd36 : 128'd14);
                if (resp_id == 1'b0) n_id0++;
                n_resp++;
                resp_cycle = cyc;
                if (n_resp == 128) begin
                    step(); cyc++;
                    chk("wrap_half_count", 128'(op_count), 128'd128);
                    continue;
                end
            end
            step();
            cyc++;
        end
        req_valid = 2'b00;
        chk("wrap_responses", 128'(n_resp), 128'd256);
        chk("wrap_last_cycle", 128'(resp_cycle), 128'(256 * (SETTLE + 2) - 1));
        chk("wrap_id0_share", 128'(n_id0), 128'd128);
        chk("wrap_op_count", 128'(op_count), 128'd0);
        resp_ready = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
